// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 8-digit seven-segment driver.
// Optional blank gap between owners is enabled by defining SEG_ARB_BLANK_EN.
module seg_display_arbiter #(
    parameter int                 N_SRC     = 4,
    parameter int                 DWELL_W   = 24,
    parameter logic [DWELL_W-1:0] DWELL_CYC = 24'd10_000_000,
    parameter logic [7:0]         BLANK_CYC = 8'd4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_SRC-1:0]     req,
    input  logic [N_SRC-1:0]     mode_in,
    input  logic [64*N_SRC-1:0]  data_in,
    input  logic                 hold,
    output logic [N_SRC-1:0]     gnt,
    output logic [63:0]          disp_data,
    output logic                 disp_mode,
    output logic                 busy
);
    localparam int LW = $clog2(N_SRC);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   gnt_q, gnt_d;
    logic [LW-1:0]      last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         blank_q, blank_d;
    logic [63:0]        disp_data_q, disp_data_d;
    logic               disp_mode_q, disp_mode_d;
    logic [LW-1:0]      pick;
    logic               pick_vld;
    logic [N_SRC-1:0]   last_oh;
    logic               others;
    logic               go;
    int                 idx;

    // round-robin scan from last+1 upward; nearest requester wins, last owner is checked last
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (req[idx]) begin
                pick     = LW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // next-state, grant, dwell/blank counters and registered display outputs
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        dwell_d     = dwell_q;
        blank_d     = blank_q;
        disp_data_d = '1;
        disp_mode_d = 1'b1;
        go          = 1'b0;
        last_oh     = '0;
        last_oh[last_q] = 1'b1;
        others      = |(req & ~last_oh);
        case (state_q)
            IDLE: go = pick_vld;
            SHOW: begin
                disp_data_d = data_in[64*int'(last_q) +: 64];
                disp_mode_d = mode_in[last_q];
                if (dwell_q != '0) dwell_d = dwell_q - 1'b1;
                if (!req[last_q] || (dwell_q == '0 && !hold && others)) begin
                    gnt_d   = '0;
                    blank_d = BLANK_CYC - 8'd1;
`ifdef SEG_ARB_BLANK_EN
                    state_d = pick_vld ? BLANK : IDLE;
`else
                    state_d = IDLE;
                    go      = pick_vld;
`endif
                end else if (dwell_q == '0) begin
                    dwell_d = DWELL_CYC;
                end
            end
            BLANK: begin
                gnt_d = '0;
                if (blank_q != 8'd0) blank_d = blank_q - 8'd1;
                else if (pick_vld) go = 1'b1;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            state_d     = SHOW;
            gnt_d       = '0;
            gnt_d[pick] = 1'b1;
            last_d      = pick;
            dwell_d     = DWELL_CYC;
        end
    end

    // state and output registers; async reset forces the blank, ungranted panel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_q      <= LW'(N_SRC - 1);
            dwell_q     <= '0;
            blank_q     <= '0;
            disp_data_q <= '1;
            disp_mode_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            dwell_q     <= dwell_d;
            blank_q     <= blank_d;
            disp_data_q <= disp_data_d;
            disp_mode_q <= disp_mode_d;
        end
    end

    assign gnt       = gnt_q;
    assign disp_data = disp_data_q;
    assign disp_mode = disp_mode_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed checks of grant order, dwell, hold, preemption and reset.
module tb_seg_display_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           hold = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   mode_in = '1;
    logic [64*N-1:0] data_in = '0;
    logic [N-1:0]   gnt;
    logic [63:0]    disp_data;
    logic           disp_mode;
    logic           busy;
    int             n_vec = 0;
    int             n_err = 0;

    seg_display_arbiter #(
        .N_SRC(N), .DWELL_W(24), .DWELL_CYC(24'd8), .BLANK_CYC(8'd2)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .mode_in(mode_in), .data_in(data_in),
        .hold(hold), .gnt(gnt), .disp_data(disp_data), .disp_mode(disp_mode), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [N-1:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) tick();
            check(tag, 64'(gnt), 64'(val));
        end
    endtask

    task automatic do_reset;
        req  = '0;
        hold = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_data", disp_data, '1);
        check("rst_mode", 64'(disp_mode), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        repeat (5) tick();
        check("idle_gnt", 64'(gnt), 64'd0);
        check("idle_data", disp_data, '1);
        check("idle_mode", 64'(disp_mode), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        data_in[64 +: 64] = 64'h1234_5678;
        mode_in[1] = 1'b0;
        req = 4'b0010;
        tick();
        check("a_gnt", 64'(gnt), 64'h2);
        check("a_busy", 64'(busy), 64'd1);
        check("a_blank1", disp_data, '1);
        tick();
        check("a_data", disp_data, 64'h1234_5678);
        check("a_mode", 64'(disp_mode), 64'd0);
        run("a_keep", 4'b0010, 30);
        data_in[64 +: 64] = 64'hDEAD_BEEF_0000_0001;
        tick();
        check("a_live", disp_data, 64'hDEAD_BEEF_0000_0001);
        req = 4'b0000;
        tick();
        check("a_drop_gnt", 64'(gnt), 64'd0);
        check("a_drop_busy", 64'(busy), 64'd0);
        tick();
        check("a_drop_data", disp_data, '1);
        check("a_drop_mode", 64'(disp_mode), 64'd1);

        do_reset();
        data_in[0 +: 64]   = 64'hAAAA_0000_AAAA_0000;
        data_in[128 +: 64] = 64'hCCCC_CCCC_0000_CCCC;
        mode_in = 4'b1110;
`ifdef SEG_ARB_BLANK_EN
        req = 4'b1011;
        tick(); run("rr_g0", 4'b0001, 9);
        tick(); run("rr_b0", 4'b0000, 2);
        check("rr_b0_data", disp_data, '1);
        check("rr_b0_mode", 64'(disp_mode), 64'd1);
        check("rr_b0_busy", 64'(busy), 64'd1);
        tick(); run("rr_g1", 4'b0010, 9);
        tick(); run("rr_b1", 4'b0000, 2);
        tick(); run("rr_g3", 4'b1000, 9);
        tick(); run("rr_b3", 4'b0000, 2);
        tick(); run("rr_g0b", 4'b0001, 1);
`else
        req = 4'b0101;
        tick(); run("nb_g0", 4'b0001, 8);
        tick();
        check("nb_g0_end", 64'(gnt), 64'h1);
        check("nb_d0", disp_data, 64'hAAAA_0000_AAAA_0000);
        check("nb_m0", 64'(disp_mode), 64'd0);
        tick();
        check("nb_hand", 64'(gnt), 64'h4);
        check("nb_noblank", disp_data, 64'hAAAA_0000_AAAA_0000);
        tick();
        check("nb_g2", 64'(gnt), 64'h4);
        check("nb_d2", disp_data, 64'hCCCC_CCCC_0000_CCCC);
        check("nb_m2", 64'(disp_mode), 64'd1);
        tick(); run("nb_g2_run", 4'b0100, 7);
        tick(); run("nb_back0", 4'b0001, 1);
`endif
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_data", disp_data, 64'hAAAA_0000_AAAA_0000);
        do_reset();

        req  = 4'b0011;
        hold = 1'b1;
        tick(); run("hold_keep", 4'b0001, 30);
        hold = 1'b0;
        tick(); run("hold_tail", 4'b0001, 6);
        tick();
`ifdef SEG_ARB_BLANK_EN
        check("hold_rot", 64'(gnt), 64'd0);
        tick(); tick();
        check("hold_next", 64'(gnt), 64'h2);
`else
        check("hold_rot", 64'(gnt), 64'h2);
`endif

        do_reset();
        req = 4'b0100;
        tick(); run("pre_g2", 4'b0100, 4);
        req = 4'b1000;
`ifdef SEG_ARB_BLANK_EN
        tick(); run("pre_blank", 4'b0000, 2);
`endif
        tick(); run("pre_g3", 4'b1000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
